toy_phase_monitor: RTL and testbench

Downstream checker/consumer for the 3-bit toy ring state machine. It samples the machine's `state` and the `en` that drives it, and checks every step against the legal sequence 000→001→010→100→000. Completed wraps are counted and reported as timestamped events through a small valid/ready FIFO, with sticky error and overflow flags. It is the runtime counterpart to the formal onehot and wrap properties on the ring.

---
 rtl/toy_phase_monitor.sv | 159 +++++++++++++++
 tb/tb_toy_phase_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/toy_phase_monitor.sv
// Runtime checker for the 3-bit toy ring (000->001->010->100->000): flags illegal steps,
// counts completed wraps and queues a timestamp per wrap in a small valid/ready FIFO.
module toy_phase_monitor #(
  parameter int DEPTH = 4,
  parameter int TS_W  = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       state,
  input  logic             clr,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] wrap_cnt,
  output logic             err,
  output logic [1:0]       err_code,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  localparam logic [1:0] CODE_NONE   = 2'b00;
  localparam logic [1:0] CODE_ONEHOT = 2'b01;
  localparam logic [1:0] CODE_EN     = 2'b10;
  localparam logic [1:0] CODE_SUCC   = 2'b11;

  // Illegal predecessors map to 111, which no onehot0 state can ever match.
  function automatic logic [2:0] nxt(input logic [2:0] s);
    case (s)
      3'b000:  nxt = 3'b001;
      3'b001:  nxt = 3'b010;
      3'b010:  nxt = 3'b100;
      3'b100:  nxt = 3'b000;
      default: nxt = 3'b111;
    endcase
  endfunction

  logic [2:0]       prev_state_r;
  logic             en_q_r;
  logic [TS_W-1:0]  ts_r;
  logic [CNT_W-1:0] wrap_cnt_r;
  logic             err_r;
  logic [1:0]       err_code_r;
  logic             ovf_r;
  logic [TS_W-1:0]  mem_r [DEPTH];
  logic [AW-1:0]    rd_ptr_r;
  logic [AW-1:0]    wr_ptr_r;
  logic [AW:0]      count_r;
  logic             evt_valid_r;
  logic [TS_W-1:0]  evt_ts_r;

  logic             step_s;
  logic             err_cond_s;
  logic [1:0]       new_code_s;
  logic             wrap_s;
  logic             pop_s;
  logic             full_s;
  logic             push_s;
  logic             drop_s;
  logic [AW-1:0]    rd_nxt_s;
  logic [AW:0]      count_nxt_s;

  // Step classification, error priority, wrap detection and FIFO handshake decode.
  always_comb begin
    step_s     = (state != prev_state_r);
    err_cond_s = 1'b1;
    new_code_s = CODE_NONE;
    if ((state & (state - 3'b001)) != 3'b000) begin
      new_code_s = CODE_ONEHOT;
    end else if (step_s != en_q_r) begin
      new_code_s = CODE_EN;
    end else if (step_s && (state != nxt(prev_state_r))) begin
      new_code_s = CODE_SUCC;
    end else begin
      err_cond_s = 1'b0;
    end
    wrap_s   = step_s && (prev_state_r == 3'b100) && (state == 3'b000) && !err_cond_s;
    pop_s    = evt_valid_r && evt_ready;
    full_s   = (count_r == FULL_LVL);
    push_s   = wrap_s && (!full_s || pop_s);
    drop_s   = wrap_s && full_s && !pop_s;
    rd_nxt_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + (AW+1)'(1);
      2'b01:   count_nxt_s = count_r - (AW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Event storage; pointers and occupancy live in the control block below.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_r[wr_ptr_r] <= ts_r;
    end
  end

  // History, timestamp, FIFO control, registered head and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_state_r <= 3'b000;
      en_q_r       <= 1'b0;
      ts_r         <= {TS_W{1'b0}};
      rd_ptr_r     <= {AW{1'b0}};
      wr_ptr_r     <= {AW{1'b0}};
      count_r      <= {(AW+1){1'b0}};
      evt_valid_r  <= 1'b0;
      evt_ts_r     <= {TS_W{1'b0}};
      wrap_cnt_r   <= {CNT_W{1'b0}};
      err_r        <= 1'b0;
      err_code_r   <= CODE_NONE;
      ovf_r        <= 1'b0;
    end else begin
      prev_state_r <= state;
      en_q_r       <= en;
      ts_r         <= ts_r + TS_W'(1);
      rd_ptr_r     <= rd_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      count_r     <= count_nxt_s;
      evt_valid_r <= (count_nxt_s != {(AW+1){1'b0}});
      // A push into the slot that becomes the head must be forwarded, since mem_r is not yet written.
      evt_ts_r    <= (push_s && (wr_ptr_r == rd_nxt_s)) ? ts_r : mem_r[rd_nxt_s];

      if (err_cond_s) begin
        err_r <= 1'b1;
      end else if (clr) begin
        err_r <= 1'b0;
      end
      if (err_cond_s && (!err_r || clr)) begin
        err_code_r <= new_code_s;
      end else if (clr) begin
        err_code_r <= CODE_NONE;
      end

      if (clr) begin
        wrap_cnt_r <= wrap_s ? CNT_W'(1) : {CNT_W{1'b0}};
      end else if (wrap_s && (wrap_cnt_r != {CNT_W{1'b1}})) begin
        wrap_cnt_r <= wrap_cnt_r + CNT_W'(1);
      end

      if (drop_s) begin
        ovf_r <= 1'b1;
      end else if (clr) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign evt_valid = evt_valid_r;
  assign evt_ts    = evt_ts_r;
  assign wrap_cnt  = wrap_cnt_r;
  assign err       = err_r;
  assign err_code  = err_code_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_toy_phase_monitor.sv
// Bench for toy_phase_monitor: directed scenarios plus randomized ring/handshake traffic
// compared against a queue-based reference model of the checking rules.
module tb_toy_phase_monitor;

  localparam int DEPTH = 4;
  localparam int TS_W  = 16;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       state;
  logic             clr;
  logic             evt_ready;
  logic             evt_valid;
  logic [TS_W-1:0]  evt_ts;
  logic [CNT_W-1:0] wrap_cnt;
  logic             err;
  logic [1:0]       err_code;
  logic             ovf;

  int checks = 0;
  int errors = 0;

  // Bench-side ring and reference model state.
  logic [2:0]      ring;
  logic [2:0]      m_prev;
  logic            m_enq;
  logic [TS_W-1:0] m_ts;
  logic [TS_W-1:0] m_q[$];
  int              m_wrap;
  logic            m_err;
  logic [1:0]      m_code;
  logic            m_ovf;
  int              succ[int] = '{0: 1, 1: 2, 2: 4, 4: 0};

  toy_phase_monitor #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .state(state), .clr(clr), .evt_ready(evt_ready),
    .evt_valid(evt_valid), .evt_ts(evt_ts), .wrap_cnt(wrap_cnt), .err(err),
    .err_code(err_code), .ovf(ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] nx(input logic [2:0] s);
    int k;
    k = int'(s);
    return succ.exists(k) ? 3'(succ[k]) : 3'b111;
  endfunction

  // Apply the rules to the inputs present in the current cycle.
  task automatic model_step();
    bit onehot, step, econd, wrap, pop, full;
    logic [1:0] c;
    if (!rst) begin
      m_prev = 3'b000; m_enq = 1'b0; m_ts = '0; m_q.delete();
      m_wrap = 0; m_err = 1'b0; m_code = 2'b00; m_ovf = 1'b0;
      return;
    end
    onehot = ($countones(state) <= 1);
    step   = (state != m_prev);
    econd  = 1'b1;
    c      = 2'b00;
    if (!onehot) c = 2'b01;
    else if (step != m_enq) c = 2'b10;
    else if (step && state != nx(m_prev)) c = 2'b11;
    else econd = 1'b0;
    wrap = step && m_prev == 3'b100 && state == 3'b000 && !econd;
    pop  = (m_q.size() > 0) && evt_ready;
    full = (m_q.size() == DEPTH);
    if (pop) void'(m_q.pop_front());
    if (clr) begin
      m_ovf = 1'b0;
      m_wrap = 0;
      if (!econd) begin m_err = 1'b0; m_code = 2'b00; end
    end
    if (econd) begin
      if (!m_err || clr) m_code = c;
      m_err = 1'b1;
    end
    if (wrap) begin
      if (!full || pop) m_q.push_back(m_ts);
      else m_ovf = 1'b1;
      if (m_wrap < 255) m_wrap++;
    end
    m_prev = state;
    m_enq  = en;
    m_ts   = m_ts + 16'd1;
  endtask

  task automatic tick();
    logic [2:0] ring_nxt;
    model_step();
    ring_nxt = !rst ? 3'b000 : (en ? nx(ring) : ring);
    @(posedge clk);
    #1;
    ring  = ring_nxt;
    state = ring;
  endtask

  task automatic apply_reset();
    rst = 1'b0; en = 1'b0; clr = 1'b0; evt_ready = 1'b0; ring = 3'b000; state = 3'b000;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL reset_evt_valid got %b exp 0", evt_valid); end
    checks++; if (evt_ts !== 16'd0) begin errors++; $display("FAIL reset_evt_ts got %0d exp 0", evt_ts); end
    checks++; if (wrap_cnt !== 8'd0) begin errors++; $display("FAIL reset_wrap_cnt got %0d exp 0", wrap_cnt); end
    checks++; if ({err, err_code, ovf} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {err, err_code, ovf}); end
  endtask

  task automatic test_basic_wraps();
    apply_reset();
    en = 1'b1;
    repeat (8) tick();
    en = 1'b0;
    tick();
    checks++; if (wrap_cnt !== 8'd2) begin errors++; $display("FAIL basic_wrap_cnt got %0d exp 2", wrap_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL basic_err got %b exp 0", err); end
    checks++; if (evt_valid !== 1'b1 || evt_ts !== 16'd4) begin errors++; $display("FAIL basic_evt0 got v=%b ts=%0d exp v=1 ts=4", evt_valid, evt_ts); end
    evt_ready = 1'b1;
    tick();
    checks++; if (evt_valid !== 1'b1 || evt_ts !== 16'd8) begin errors++; $display("FAIL basic_evt1 got v=%b ts=%0d exp v=1 ts=8", evt_valid, evt_ts); end
    tick();
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", evt_valid); end
  endtask

  task automatic test_onehot_err();
    apply_reset();
    state = 3'b011;
    tick();
    checks++; if (err !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL onehot_code got err=%b code=%b exp err=1 code=01", err, err_code); end
    en = 1'b1;
    tick();
    en = 1'b0;
    state = 3'b010;
    tick();
    checks++; if (err !== 1'b1 || err_code !== 2'b01) begin errors++; $display("FAIL onehot_hold got err=%b code=%b exp err=1 code=01", err, err_code); end
  endtask

  task automatic test_enable_mismatch();
    apply_reset();
    en = 1'b1;
    tick();
    en = 1'b0;
    tick();
    state = 3'b010;
    tick();
    checks++; if (err !== 1'b1 || err_code !== 2'b10) begin errors++; $display("FAIL en_code got err=%b code=%b exp err=1 code=10", err, err_code); end
    tick();
    tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (err !== 1'b0 || err_code !== 2'b00) begin errors++; $display("FAIL en_clr got err=%b code=%b exp err=0 code=00", err, err_code); end
  endtask

  task automatic test_overflow();
    apply_reset();
    en = 1'b1;
    repeat (21) tick();
    en = 1'b0;
    tick();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_ts !== 16'(4 + 4 * i)) begin errors++; $display("FAIL ovf_drain%0d got v=%b ts=%0d exp v=1 ts=%0d", i, evt_valid, evt_ts, 4 + 4 * i); end
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b exp 0", evt_valid); end
  endtask

  task automatic test_full_pop();
    apply_reset();
    en = 1'b1;
    repeat (20) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    en = 1'b0;
    tick();
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b exp 0", ovf); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (evt_valid !== 1'b1 || evt_ts !== 16'(8 + 4 * i)) begin errors++; $display("FAIL fullpop_drain%0d got v=%b ts=%0d exp v=1 ts=%0d", i, evt_valid, evt_ts, 8 + 4 * i); end
      tick();
    end
    evt_ready = 1'b0;
    checks++; if (evt_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got %b exp 0", evt_valid); end
  endtask

  task automatic test_saturate();
    apply_reset();
    evt_ready = 1'b1;
    en = 1'b1;
    repeat (1021) tick();
    checks++; if (wrap_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d exp 255", wrap_cnt); end
    repeat (4) tick();
    checks++; if (wrap_cnt !== 8'd255) begin errors++; $display("FAIL sat_hold got %0d exp 255", wrap_cnt); end
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    checks++; if (wrap_cnt !== 8'd1) begin errors++; $display("FAIL sat_clr_wrap got %0d exp 1", wrap_cnt); end
    en = 1'b0;
    evt_ready = 1'b0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 1500; n++) begin
      en        = ($urandom_range(0, 3) != 0);
      evt_ready = ($urandom_range(0, 2) == 0);
      clr       = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 29) == 0) state = 3'($urandom_range(0, 7));
      tick();
      checks++; if (evt_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_evt_valid n=%0d got %b exp %b", n, evt_valid, m_q.size() != 0); end
      if (m_q.size() != 0) begin
        checks++; if (evt_ts !== m_q[0]) begin errors++; $display("FAIL rnd_evt_ts n=%0d got %0d exp %0d", n, evt_ts, m_q[0]); end
      end
      checks++; if (wrap_cnt !== 8'(m_wrap)) begin errors++; $display("FAIL rnd_wrap_cnt n=%0d got %0d exp %0d", n, wrap_cnt, m_wrap); end
      checks++; if (err !== m_err || err_code !== m_code) begin errors++; $display("FAIL rnd_err n=%0d got %b/%b exp %b/%b", n, err, err_code, m_err, m_code); end
      checks++; if (ovf !== m_ovf) begin errors++; $display("FAIL rnd_ovf n=%0d got %b exp %b", n, ovf, m_ovf); end
    end
    rst = 1'b1;
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_wraps();
    test_onehot_err();
    test_enable_mismatch();
    test_overflow();
    test_full_pop();
    test_saturate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
